decode_cycle: RTL and testbench
===============================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; register index width 5.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port InstrD, input, 32, instruction from fetch stage.
REQ-006 SHALL have ports PCD and PCPlus4D, input, 32 each, PC and PC+4 from fetch stage.
REQ-007 SHALL have ports RegWriteW (1), RDW (5) and ResultW (32), all inputs, writeback request, destination and data.
REQ-008 SHALL have port FlushE, input, 1, squashes the instruction entering execute.
REQ-009 SHALL have control outputs RegWriteE, MemWriteE, ALUSrcE, BranchE and ResultSrcE, 1 bit each.
REQ-010 SHALL have output ALUControlE, 3 bits, ALU operation.
REQ-011 SHALL have outputs RD1_E, RD2_E, Imm_Ext_E, PCE and PCPlus4E, 32 bits each.
REQ-012 SHALL have outputs RD_E, RS1_E and RS2_E, 5 bits each, register indices for hazard logic.

Function
REQ-013 Decode opcode InstrD[6:0]: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011.
REQ-014 Control per opcode:
- lw: RegWrite=1, ALUSrc=1, ResultSrc=1, ALU op add.
- sw: MemWrite=1, ALUSrc=1, ALU op add.
- R-type and I-ALU: RegWrite=1; I-ALU also sets ALUSrc=1.
- beq: Branch=1, ALU op sub.
REQ-015 Unrecognised opcode SHALL produce all-zero control (bubble).
REQ-016 ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-017 R/I-ALU ALU op from funct3 InstrD[14:12] and funct7[5]:
- funct3 000 is add, except R-type with funct7[5]=1, which is sub.
- funct3 010 is slt, 110 is or, 111 is and.
- Any other funct3 is add.
REQ-018 Immediate, sign-extended to 32 bits from InstrD[31]:
- I: [31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- Immediate is 0 for R-type and unrecognised opcodes.
REQ-019 Register file: NREGS x XLEN, two combinational read ports indexed by rs1=InstrD[19:15] and rs2=InstrD[24:20].
REQ-020 Register file write SHALL occur on posedge clk when RegWriteW=1 and RDW!=0.
REQ-021 x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-022 Read port SHALL return ResultW when RegWriteW=1, RDW equals the read index and RDW!=0; writeback and decode in the same cycle yields new data.
REQ-023 ID/EX register SHALL capture on every posedge clk: all control, RD1, RD2, immediate, PCD, PCPlus4D, rd=InstrD[11:7], rs1 and rs2. Latency from InstrD to the E outputs is exactly 1 cycle.
REQ-024 FlushE=1 at posedge SHALL load all control outputs with 0. Data fields SHALL still capture normally.
REQ-025 FlushE SHALL NOT block a simultaneous register file write.

Reset
REQ-026 rst low SHALL asynchronously clear all ID/EX outputs to 0 and all register file entries to 0.
REQ-027 While rst is low, register file writes SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight ID/EX contents.
REQ-029 First capture after reset deassertion SHALL occur at the first posedge with rst high.

Structure
REQ-030 A shared package SHALL hold opcode constants, ALUControl encodings, immediate-type enum, and XLEN/NREGS defaults.
REQ-031 Register file SHALL be a separate sub-module named Register_File; control decode, immediate extension and the ID/EX register SHALL stay in decode_cycle.

Verification
REQ-032 Reset: assert rst low mid-run -> all E outputs 0 immediately; after release, reading x5 returns 0.
REQ-033 Write then read:
- Cycle 1: RegWriteW=1, RDW=5, ResultW=0x0000_00AA.
- Next cycle: InstrD=0x0052_8333 (add x6,x5,x5).
- Required: RD1_E=RD2_E=0xAA, ALUControlE=000, RegWriteE=1, RD_E=6.
REQ-034 Bypass: same-cycle writeback RDW=5, ResultW=0x1234 while InstrD reads x5 -> RD1_E=0x1234 one cycle later.
REQ-035 x0 protection: write RDW=0, ResultW=0xFFFF_FFFF, then read x0 -> RD1_E=0.
REQ-036 Immediates:
- InstrD=0xFFC4_A303 (lw x6,-4(x9)): Imm_Ext_E=0xFFFF_FFFC, ResultSrcE=1, ALUSrcE=1.
- beq with offset -8: Imm_Ext_E=0xFFFF_FFF8, BranchE=1, ALUControlE=001.
REQ-037 Flush: FlushE=1 with a valid sw in InstrD -> next cycle MemWriteE=0 and RegWriteE=0, PCE=PCD.

Source files
------------

// File: rtl/decode_cycle_pkg.sv
// decode_cycle_pkg: opcodes, ALU encodings, control bundle and immediate-type helper for the decode stage
package decode_cycle_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} immType_t;
    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       aluSrc;
        logic       branch;
        logic       resultSrc;
        logic [2:0] aluCtl;
    } ctrl_t;
    function automatic immType_t immTypeOf(input logic [6:0] op);
        return (op == OP_LW || op == OP_I) ? IMM_I :
               op == OP_SW ? IMM_S :
               op == OP_BEQ ? IMM_B : IMM_NONE;
    endfunction
endpackage

// File: rtl/decode_cycle_if.sv
// decode_cycle_if: fetch/writeback inputs and ID/EX outputs of the decode stage
interface decode_cycle_if #(parameter int XLEN = 32);
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            RegWriteW;
    logic [4:0]      RDW;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            ALUSrcE;
    logic            BranchE;
    logic            ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RD_E;
    logic [4:0]      RS1_E;
    logic [4:0]      RS2_E;
    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  RegWriteE, MemWriteE, ALUSrcE, BranchE, ResultSrcE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E
    );
    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output RegWriteE, MemWriteE, ALUSrcE, BranchE, ResultSrcE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E
    );
endinterface

// File: rtl/decode_cycle_regfile.sv
// Register_File: two combinational read ports with writeback bypass, x0 hardwired to zero
module Register_File #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREGS];
    logic            wrEn;
    assign wrEn = we && rd != 5'd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wrEn) begin
            regs[rd] <= wd;
        end
    end
    // same-cycle writeback is forwarded so decode sees the new value
    assign rd1 = rs1 == 5'd0 ? '0 : (wrEn && rd == rs1) ? wd : regs[rs1];
    assign rd2 = rs2 == 5'd0 ? '0 : (wrEn && rd == rs2) ? wd : regs[rs2];
endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: control decode, immediate extension, register file read and ID/EX pipeline register
module decode_cycle
    import decode_cycle_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input logic           clk,
    input logic           rst,
    decode_cycle_if.slave bus
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            isR, isI;
    logic [2:0]      aluOpRI;
    ctrl_t           ctrlD, ctrlE;
    immType_t        immType;
    logic [XLEN-1:0] immD, rd1D, rd2D;
    assign opcode  = bus.InstrD[6:0];
    assign funct3  = bus.InstrD[14:12];
    assign isR     = opcode == OP_R;
    assign isI     = opcode == OP_I;
    assign immType = immTypeOf(opcode);
    assign aluOpRI = funct3 == 3'b000 ? ((isR && bus.InstrD[30]) ? ALU_SUB : ALU_ADD) :
                     funct3 == 3'b010 ? ALU_SLT :
                     funct3 == 3'b110 ? ALU_OR :
                     funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    always_comb begin
        ctrlD           = '0;
        ctrlD.regWrite  = opcode == OP_LW || isR || isI;
        ctrlD.memWrite  = opcode == OP_SW;
        ctrlD.aluSrc    = opcode == OP_LW || opcode == OP_SW || isI;
        ctrlD.branch    = opcode == OP_BEQ;
        ctrlD.resultSrc = opcode == OP_LW;
        ctrlD.aluCtl    = (isR || isI) ? aluOpRI : opcode == OP_BEQ ? ALU_SUB : ALU_ADD;
    end
    always_comb begin
        immD = immType == IMM_I ? {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]} :
               immType == IMM_S ? {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]} :
               immType == IMM_B ? {{(XLEN-13){bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[7],
                                   bus.InstrD[30:25], bus.InstrD[11:8], 1'b0} : '0;
    end
    Register_File #(.XLEN(XLEN), .NREGS(NREGS)) rf (
        .clk (clk),
        .rst (rst),
        .rs1 (bus.InstrD[19:15]),
        .rs2 (bus.InstrD[24:20]),
        .we  (bus.RegWriteW),
        .rd  (bus.RDW),
        .wd  (bus.ResultW),
        .rd1 (rd1D),
        .rd2 (rd2D)
    );
    // a flush squashes only control; data fields keep flowing for hazard visibility
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlE         <= '0;
            bus.RD1_E     <= '0;
            bus.RD2_E     <= '0;
            bus.Imm_Ext_E <= '0;
            bus.PCE       <= '0;
            bus.PCPlus4E  <= '0;
            bus.RD_E      <= '0;
            bus.RS1_E     <= '0;
            bus.RS2_E     <= '0;
        end else begin
            ctrlE         <= bus.FlushE ? '0 : ctrlD;
            bus.RD1_E     <= rd1D;
            bus.RD2_E     <= rd2D;
            bus.Imm_Ext_E <= immD;
            bus.PCE       <= bus.PCD;
            bus.PCPlus4E  <= bus.PCPlus4D;
            bus.RD_E      <= bus.InstrD[11:7];
            bus.RS1_E     <= bus.InstrD[19:15];
            bus.RS2_E     <= bus.InstrD[24:20];
        end
    end
    assign bus.RegWriteE   = ctrlE.regWrite;
    assign bus.MemWriteE   = ctrlE.memWrite;
    assign bus.ALUSrcE     = ctrlE.aluSrc;
    assign bus.BranchE     = ctrlE.branch;
    assign bus.ResultSrcE  = ctrlE.resultSrc;
    assign bus.ALUControlE = ctrlE.aluCtl;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed vectors against hand-computed decode results
module tb_decode_cycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nPass = 0;
    decode_cycle_if #(.XLEN(32)) bus ();
    decode_cycle dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.InstrD = '0; bus.PCD = '0; bus.PCPlus4D = '0;
        bus.RegWriteW = 1'b0; bus.RDW = '0; bus.ResultW = '0; bus.FlushE = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        check("rst_pce", bus.PCE, 32'd0);
        check("rst_rd1", bus.RD1_E, 32'd0);
        rst = 1'b1;
        // write x5 = 0xAA, then add x6,x5,x5
        bus.RegWriteW = 1'b1; bus.RDW = 5'd5; bus.ResultW = 32'h0000_00AA;
        step();
        bus.RegWriteW = 1'b0;
        bus.InstrD = 32'h0052_8333; bus.PCD = 32'h100; bus.PCPlus4D = 32'h104;
        step();
        check("wr_rd1", bus.RD1_E, 32'hAA);
        check("wr_rd2", bus.RD2_E, 32'hAA);
        check("wr_aluctl", {29'd0, bus.ALUControlE}, 32'd0);
        check("wr_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
        check("wr_alusrc", {31'd0, bus.ALUSrcE}, 32'd0);
        check("wr_rd", {27'd0, bus.RD_E}, 32'd6);
        check("wr_rs1", {27'd0, bus.RS1_E}, 32'd5);
        check("wr_pce", bus.PCE, 32'h100);
        check("wr_pc4e", bus.PCPlus4E, 32'h104);
        // same-cycle bypass
        bus.RegWriteW = 1'b1; bus.RDW = 5'd5; bus.ResultW = 32'h1234;
        step();
        check("byp_rd1", bus.RD1_E, 32'h1234);
        check("byp_rd2", bus.RD2_E, 32'h1234);
        bus.RegWriteW = 1'b0;
        step();
        check("byp_kept", bus.RD1_E, 32'h1234);
        // x0 protection, same cycle and after
        bus.RegWriteW = 1'b1; bus.RDW = 5'd0; bus.ResultW = 32'hFFFF_FFFF;
        bus.InstrD = 32'h0000_0333;
        step();
        check("x0_byp", bus.RD1_E, 32'd0);
        bus.RegWriteW = 1'b0;
        step();
        check("x0_read", bus.RD1_E, 32'd0);
        // ALU op selection
        bus.InstrD = 32'h4052_8333; step();
        check("sub_aluctl", {29'd0, bus.ALUControlE}, 32'd1);
        bus.InstrD = 32'h0052_F333; step();
        check("and_aluctl", {29'd0, bus.ALUControlE}, 32'd2);
        bus.InstrD = 32'h0052_A333; step();
        check("slt_aluctl", {29'd0, bus.ALUControlE}, 32'd5);
        check("r_imm", bus.Imm_Ext_E, 32'd0);
        bus.InstrD = 32'hFFF2_8313; step();
        check("addi_aluctl", {29'd0, bus.ALUControlE}, 32'd0);
        check("addi_imm", bus.Imm_Ext_E, 32'hFFFF_FFFF);
        check("addi_alusrc", {31'd0, bus.ALUSrcE}, 32'd1);
        bus.InstrD = 32'h07F2_E313; step();
        check("ori_aluctl", {29'd0, bus.ALUControlE}, 32'd3);
        check("ori_imm", bus.Imm_Ext_E, 32'h7F);
        // unrecognised opcode is a bubble
        bus.InstrD = 32'hFFFF_FFFF; step();
        check("bad_ctrl", {24'd0, bus.RegWriteE, bus.MemWriteE, bus.ALUSrcE, bus.BranchE,
                           bus.ResultSrcE, bus.ALUControlE}, 32'd0);
        check("bad_imm", bus.Imm_Ext_E, 32'd0);
        // beq x5,x5,-8
        bus.InstrD = 32'hFE52_8CE3; step();
        check("beq_imm", bus.Imm_Ext_E, 32'hFFFF_FFF8);
        check("beq_branch", {31'd0, bus.BranchE}, 32'd1);
        check("beq_aluctl", {29'd0, bus.ALUControlE}, 32'd1);
        check("beq_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        // sw x5,-4(x9)
        bus.InstrD = 32'hFE54_AE23; step();
        check("sw_imm", bus.Imm_Ext_E, 32'hFFFF_FFFC);
        check("sw_memwrite", {31'd0, bus.MemWriteE}, 32'd1);
        check("sw_alusrc", {31'd0, bus.ALUSrcE}, 32'd1);
        // flush with sw in decode, plus concurrent writeback to x7
        bus.FlushE = 1'b1; bus.PCD = 32'h200;
        bus.RegWriteW = 1'b1; bus.RDW = 5'd7; bus.ResultW = 32'h77;
        step();
        check("fl_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
        check("fl_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        check("fl_alusrc", {31'd0, bus.ALUSrcE}, 32'd0);
        check("fl_pce", bus.PCE, 32'h200);
        check("fl_imm", bus.Imm_Ext_E, 32'hFFFF_FFFC);
        bus.FlushE = 1'b0; bus.RegWriteW = 1'b0;
        bus.InstrD = 32'h0003_8333; step();
        check("fl_wb_x7", bus.RD1_E, 32'h77);
        // lw x6,-4(x9)
        bus.InstrD = 32'hFFC4_A303; step();
        check("lw_imm", bus.Imm_Ext_E, 32'hFFFF_FFFC);
        check("lw_resultsrc", {31'd0, bus.ResultSrcE}, 32'd1);
        check("lw_alusrc", {31'd0, bus.ALUSrcE}, 32'd1);
        check("lw_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
        check("lw_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
        // mid-run asynchronous reset
        rst = 1'b0;
        #1;
        check("mrst_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        check("mrst_imm", bus.Imm_Ext_E, 32'd0);
        check("mrst_pce", bus.PCE, 32'd0);
        check("mrst_rd", {27'd0, bus.RD_E}, 32'd0);
        bus.RegWriteW = 1'b1; bus.RDW = 5'd5; bus.ResultW = 32'hDEAD;
        step();
        check("mrst_hold", bus.RD1_E, 32'd0);
        rst = 1'b1;
        bus.RegWriteW = 1'b0;
        bus.InstrD = 32'h0052_8333;
        step();
        check("mrst_x5", bus.RD1_E, 32'd0);
        check("mrst_cap_rd", {27'd0, bus.RD_E}, 32'd6);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
